intra4x4_resid_sad: RTL and testbench



---
 rtl/intra_pred_pkg.sv | 36 +++
 rtl/intra_lane_absdiff.sv | 34 +++
 rtl/intra4x4_resid_sad.sv | 187 ++++++++++++++++++
 tb/tb_intra4x4_resid_sad.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intra_pred_pkg.sv
// Shared types and width helpers for the intra 4x4 residual / SAD path.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package intra_pred_pkg;

  // H.264 intra 4x4 prediction modes, numbered as the predictor bank emits them.
  typedef enum logic [3:0] {
    VERT = 4'd0,
    HOR  = 4'd1,
    DC   = 4'd2,
    DDL  = 4'd3,
    DDR  = 4'd4,
    VR   = 4'd5,
    HD   = 4'd6,
    VL   = 4'd7,
    HU   = 4'd8
  } mode_e;

  // Block-level control: gather beats, scan SADs, then present the decision.
  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    SELECT = 2'd1,
    DONE   = 2'd2
  } state_e;

  // One extra bit holds the full signed range of (mb - pred) without wrap.
  function automatic int res_w(input int pix_w);
    return pix_w + 1;
  endfunction

  // Worst case SAD is npix * (2**pix_w - 1), which always fits here.
  function automatic int sad_w(input int pix_w, input int npix);
    return pix_w + $clog2(npix);
  endfunction

endpackage

// File: rtl/intra_lane_absdiff.sv
// Per-mode lane residuals (mb - pred, signed, one bit wider) and the beat's sum of |res|.
// Latency: combinational.
// Backpressure: none; the parent registers the result only on an accepted beat.
module intra_lane_absdiff
  import intra_pred_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int LANES = 4,
  parameter int SUM_W = 12
) (
  input  logic [LANES*PIX_W-1:0]        mb,
  input  logic [LANES*PIX_W-1:0]        pred,
  output logic [LANES*res_w(PIX_W)-1:0] res,
  output logic [SUM_W-1:0]              abs_sum
);

  localparam int RES_W = res_w(PIX_W);

  // Magnitude of a residual; the most negative value is -(2**PIX_W - 1), so PIX_W bits suffice.
  function automatic logic [PIX_W-1:0] absv(input logic [PIX_W:0] d);
    return d[PIX_W] ? PIX_W'(-d) : d[PIX_W-1:0];
  endfunction

  // Zero-extend both pixels before subtracting so the difference never wraps, then fold |res| into the sum.
  always_comb begin
    res     = '0;
    abs_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      res[l*RES_W +: RES_W] = {1'b0, mb[l*PIX_W +: PIX_W]} - {1'b0, pred[l*PIX_W +: PIX_W]};
      abs_sum = abs_sum + SUM_W'(absv(res[l*RES_W +: RES_W]));
    end
  end

endmodule

// File: rtl/intra4x4_resid_sad.sv
// Streams signed per-mode residuals of a 4x4 block and picks the mode with the lowest SAD.
// Latency: residual beat 1 cycle after accept; decision NMODES+1 cycles after the last beat's handshake cycle.
// Backpressure: in_ready drops while a residual is stalled or outside ACCUM; decision holds until sad_ready.
// Optional: define INTRA_SAD_MODE_MASK_EN to add a per-block mode_mask candidate filter.
module intra4x4_resid_sad
  import intra_pred_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int NPIX   = 16,
  parameter int NMODES = 9,
  parameter int LANES  = 4
) (
  input  logic                               clk,
  input  logic                               reset,
`ifdef INTRA_SAD_MODE_MASK_EN
  input  logic [NMODES-1:0]                  mode_mask,
`endif
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [LANES*PIX_W-1:0]             in_mb,
  input  logic [NMODES*LANES*PIX_W-1:0]      in_pred,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [NMODES*LANES*(PIX_W+1)-1:0]  res_data,
  output logic                               res_last,
  output logic                               sad_valid,
  input  logic                               sad_ready,
  output logic [$clog2(NMODES)-1:0]          best_mode,
  output logic [PIX_W+$clog2(NPIX)-1:0]      best_sad
);

  localparam int RES_W  = res_w(PIX_W);
  localparam int SAD_W  = sad_w(PIX_W, NPIX);
  localparam int BEATS  = NPIX / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int MODE_W = $clog2(NMODES);
  localparam int VEC_W  = LANES * RES_W;

  if ((NPIX % LANES) != 0) begin : g_bad_cfg
    $error("intra4x4_resid_sad: NPIX must be a multiple of LANES");
  end

  state_e                  state, state_nxt;
  logic [BEAT_W-1:0]       beat_cnt;
  logic [MODE_W-1:0]       scan_idx;
  logic [SAD_W-1:0]        sad_acc  [NMODES];
  logic [SAD_W-1:0]        beat_sum [NMODES];
  logic [NMODES*VEC_W-1:0] res_nxt;
  logic [NMODES-1:0]       cand;
  logic                    accept;
  logic                    last_beat;
  logic                    scan_end;

  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
  assign scan_end  = (scan_idx == MODE_W'(NMODES - 1));

  for (genvar gm = 0; gm < NMODES; gm++) begin : g_mode
    intra_lane_absdiff #(
      .PIX_W (PIX_W),
      .LANES (LANES),
      .SUM_W (SAD_W)
    ) u_absdiff (
      .mb      (in_mb),
      .pred    (in_pred[gm*LANES*PIX_W +: LANES*PIX_W]),
      .res     (res_nxt[gm*VEC_W +: VEC_W]),
      .abs_sum (beat_sum[gm])
    );
  end

`ifdef INTRA_SAD_MODE_MASK_EN
  logic [NMODES-1:0] mask_q;

  // Capture the candidate set on the first beat so it stays fixed for the whole block.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
    end else if (accept && (beat_cnt == '0)) begin
      mask_q <= mode_mask;
    end
  end

  assign cand = mask_q;
`else
  assign cand = '1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the handshake outputs; in_ready is forced low during reset so every output reads 0.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    sad_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = !reset && (!res_valid || res_ready);
        if (in_valid && in_ready && last_beat) begin
          state_nxt = SELECT;
        end
      end
      SELECT: begin
        if (scan_end) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        sad_valid = 1'b1;
        if (sad_ready) begin
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Residual output slot: loads on accept, holds stable until drained; a drain and a load can share a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_last  <= 1'b0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_data  <= res_nxt;
      res_last  <= last_beat;
    end else if (res_ready) begin
      res_valid <= 1'b0;
      res_last  <= 1'b0;
    end
  end

  // Beat counting, SAD accumulation and the one-mode-per-cycle best search (strict < keeps the lowest index on ties).
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt  <= '0;
      scan_idx  <= '0;
      best_mode <= '0;
      best_sad  <= '0;
      for (int m = 0; m < NMODES; m++) begin
        sad_acc[m] <= '0;
      end
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            for (int m = 0; m < NMODES; m++) begin
              sad_acc[m] <= sad_acc[m] + beat_sum[m];
            end
            if (last_beat) begin
              beat_cnt  <= '0;
              scan_idx  <= '0;
              best_mode <= '0;
              best_sad  <= '1;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        SELECT: begin
          if (cand[scan_idx] && (sad_acc[scan_idx] < best_sad)) begin
            best_mode <= scan_idx;
            best_sad  <= sad_acc[scan_idx];
          end
          scan_idx <= scan_idx + MODE_W'(1);
        end
        DONE: begin
          if (sad_ready) begin
            beat_cnt <= '0;
            for (int m = 0; m < NMODES; m++) begin
              sad_acc[m] <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_intra4x4_resid_sad.sv
// Directed bench for intra4x4_resid_sad: residual stream, SAD decision, stalls and reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Define INTRA_SAD_MODE_MASK_EN to also exercise the mode mask.
module tb_intra4x4_resid_sad;

  localparam int PIX_W  = 8;
  localparam int NPIX   = 16;
  localparam int NMODES = 9;
  localparam int LANES  = 4;
  localparam int RES_W  = PIX_W + 1;
  localparam int BEATS  = NPIX / LANES;
  localparam int DATA_W = NMODES * LANES * RES_W;

  logic                          clk = 1'b0;
  logic                          reset = 1'b1;
  logic                          in_valid = 1'b0;
  logic                          in_ready;
  logic [LANES*PIX_W-1:0]        in_mb = '0;
  logic [NMODES*LANES*PIX_W-1:0] in_pred = '0;
  logic                          res_valid;
  logic                          res_ready = 1'b1;
  logic [DATA_W-1:0]             res_data;
  logic                          res_last;
  logic                          sad_valid;
  logic                          sad_ready = 1'b1;
  logic [3:0]                    best_mode;
  logic [11:0]                   best_sad;
`ifdef INTRA_SAD_MODE_MASK_EN
  logic [NMODES-1:0]             mode_mask = '1;
`endif

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;

  int blk_mb   [NPIX];
  int blk_pred [NMODES][NPIX];

  logic [DATA_W-1:0] rq_dat  [$];
  bit                rq_last [$];

  intra4x4_resid_sad #(
    .PIX_W  (PIX_W),
    .NPIX   (NPIX),
    .NMODES (NMODES),
    .LANES  (LANES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef INTRA_SAD_MODE_MASK_EN
    .mode_mask (mode_mask),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mb     (in_mb),
    .in_pred   (in_pred),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_last  (res_last),
    .sad_valid (sad_valid),
    .sad_ready (sad_ready),
    .best_mode (best_mode),
    .best_sad  (best_sad)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every residual beat that will transfer on the coming rising edge.
  always @(negedge clk) begin
    if (!reset && res_valid === 1'b1 && res_ready === 1'b1) begin
      rq_dat.push_back(res_data);
      rq_last.push_back(res_last);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [DATA_W-1:0] exp_res(input int b);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int m = 0; m < NMODES; m++) begin
      for (int l = 0; l < LANES; l++) begin
        r[(m*LANES+l)*RES_W +: RES_W] = RES_W'(blk_mb[b*LANES+l] - blk_pred[m][b*LANES+l]);
      end
    end
    return r;
  endfunction

  task automatic set_flat(input int mbv, input int pv);
    for (int i = 0; i < NPIX; i++) begin
      blk_mb[i] = mbv;
      for (int m = 0; m < NMODES; m++) blk_pred[m][i] = pv;
    end
  endtask

  // Present beat b and hold it until the handshake; acc is the cycle in which it is accepted.
  task automatic send_beat(input int b, output int acc, output bit to);
    int n;
    bit done;
    n = 0;
    done = 0;
    to = 0;
    acc = -1;
    for (int l = 0; l < LANES; l++) begin
      in_mb[l*PIX_W +: PIX_W] = PIX_W'(blk_mb[b*LANES+l]);
      for (int m = 0; m < NMODES; m++)
        in_pred[(m*LANES+l)*PIX_W +: PIX_W] = PIX_W'(blk_pred[m][b*LANES+l]);
    end
    in_valid = 1'b1;
    while (!done && !to) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        done = 1;
        acc = cyc;
      end else begin
        n++;
        if (n > 64) to = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_block(output int last_acc, output bit to);
    int a;
    bit t;
    to = 0;
    last_acc = -1;
    for (int b = 0; b < BEATS; b++) begin
      send_beat(b, a, t);
      to = to | t;
      last_acc = a;
    end
  endtask

  task automatic wait_decision(output int seen, output logic [3:0] bm, output logic [11:0] bs, output bit to);
    int n;
    bit got;
    n = 0;
    got = 0;
    to = 0;
    seen = -1;
    bm = 'x;
    bs = 'x;
    while (!got && !to) begin
      @(negedge clk);
      if (sad_valid === 1'b1) begin
        got = 1;
        seen = cyc;
        bm = best_mode;
        bs = best_sad;
      end else begin
        n++;
        if (n > 64) to = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_in_ready: got %0b expected 0", in_ready); end
    nchk++;
    if (res_valid !== 1'b0) begin nerr++; $display("FAIL rst_res_valid: got %0b expected 0", res_valid); end
    nchk++;
    if (res_data !== '0) begin nerr++; $display("FAIL rst_res_data: got %0h expected 0", res_data); end
    nchk++;
    if (res_last !== 1'b0) begin nerr++; $display("FAIL rst_res_last: got %0b expected 0", res_last); end
    nchk++;
    if (sad_valid !== 1'b0) begin nerr++; $display("FAIL rst_sad_valid: got %0b expected 0", sad_valid); end
    nchk++;
    if (best_mode !== 4'd0) begin nerr++; $display("FAIL rst_best_mode: got %0h expected 0", best_mode); end
    nchk++;
    if (best_sad !== 12'd0) begin nerr++; $display("FAIL rst_best_sad: got %0h expected 0", best_sad); end
    nchk++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_release_in_ready: got %0b expected 1", in_ready); end
    nchk++;
    @(posedge clk);
    #1;
  endtask

  // mb = 200; mode m predicts 200+m+1 except mode 3 which is exact.
  task automatic test_best_exact;
    int acc, seen;
    bit to, to2;
    logic [3:0] bm;
    logic [11:0] bs;
    logic [DATA_W-1:0] r0;
    for (int i = 0; i < NPIX; i++) begin
      blk_mb[i] = 200;
      for (int m = 0; m < NMODES; m++) blk_pred[m][i] = 200 + ((m == 3) ? 0 : m + 1);
    end
    rq_dat.delete();
    rq_last.delete();
    send_block(acc, to);
    wait_decision(seen, bm, bs, to2);
    if (to || to2) begin nerr++; $display("FAIL t1_timeout: got timeout expected completion"); end
    nchk++;
    if (seen - acc !== 10) begin nerr++; $display("FAIL t1_latency: got %0d expected 10", seen - acc); end
    nchk++;
    if (bm !== 4'd3) begin nerr++; $display("FAIL t1_best_mode: got %0d expected 3", bm); end
    nchk++;
    if (bs !== 12'd0) begin nerr++; $display("FAIL t1_best_sad: got %0d expected 0", bs); end
    nchk++;
    if (rq_dat.size() !== BEATS) begin nerr++; $display("FAIL t1_res_count: got %0d expected %0d", rq_dat.size(), BEATS); end
    nchk++;
    for (int b = 0; b < BEATS && b < rq_dat.size(); b++) begin
      if (rq_dat[b] !== exp_res(b)) begin nerr++; $display("FAIL t1_res_beat%0d: got %0h expected %0h", b, rq_dat[b], exp_res(b)); end
      nchk++;
      if (rq_last[b] !== (b == BEATS - 1)) begin nerr++; $display("FAIL t1_last_beat%0d: got %0b expected %0b", b, rq_last[b], (b == BEATS - 1)); end
      nchk++;
    end
    if (rq_dat.size() > 0) begin
      r0 = rq_dat[0];
      if (r0[8:0] !== 9'h1FF) begin nerr++; $display("FAIL t1_res_m0l0: got %0h expected 1ff", r0[8:0]); end
      nchk++;
      if (r0[(3*LANES)*RES_W +: RES_W] !== 9'h000) begin nerr++; $display("FAIL t1_res_m3l0: got %0h expected 0", r0[(3*LANES)*RES_W +: RES_W]); end
      nchk++;
    end
  endtask

  // mb = 0, pred = 255 everywhere: largest negative residual, equal SADs, decision held while sad_ready low.
  task automatic test_extreme_hold;
    int acc, seen;
    bit to, to2;
    logic [3:0] bm;
    logic [11:0] bs;
    set_flat(0, 255);
    rq_dat.delete();
    rq_last.delete();
    sad_ready = 1'b0;
    send_block(acc, to);
    wait_decision(seen, bm, bs, to2);
    if (to || to2) begin nerr++; $display("FAIL t2_timeout: got timeout expected completion"); end
    nchk++;
    if (bm !== 4'd0) begin nerr++; $display("FAIL t2_best_mode: got %0d expected 0", bm); end
    nchk++;
    if (bs !== 12'd4080) begin nerr++; $display("FAIL t2_best_sad: got %0d expected 4080", bs); end
    nchk++;
    if (rq_dat.size() !== BEATS) begin nerr++; $display("FAIL t2_res_count: got %0d expected %0d", rq_dat.size(), BEATS); end
    nchk++;
    for (int b = 0; b < BEATS && b < rq_dat.size(); b++) begin
      if (rq_dat[b] !== {36{9'h101}}) begin nerr++; $display("FAIL t2_res_beat%0d: got %0h expected all 101", b, rq_dat[b]); end
      nchk++;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (sad_valid !== 1'b1 || best_mode !== 4'd0 || best_sad !== 12'd4080 || in_ready !== 1'b0) begin
        nerr++;
        $display("FAIL t2_hold%0d: got valid=%0b mode=%0d sad=%0d in_ready=%0b expected 1/0/4080/0", k, sad_valid, best_mode, best_sad, in_ready);
      end
      nchk++;
    end
    @(posedge clk);
    #1;
    sad_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    if (sad_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL t2_release: got valid=%0b in_ready=%0b expected 0/1", sad_valid, in_ready);
    end
    nchk++;
    @(posedge clk);
    #1;
  endtask

  // Modes 2 and 5 tie at SAD 40 (one pixel off by 40 each way); others are at 48.
  task automatic test_tie;
    int acc, seen;
    bit to, to2;
    logic [3:0] bm;
    logic [11:0] bs;
    logic [DATA_W-1:0] r;
    set_flat(100, 103);
    for (int i = 0; i < NPIX; i++) begin
      blk_pred[2][i] = 100;
      blk_pred[5][i] = 100;
    end
    blk_pred[2][0] = 140;
    blk_pred[5][5] = 60;
    rq_dat.delete();
    rq_last.delete();
    send_block(acc, to);
    wait_decision(seen, bm, bs, to2);
    if (to || to2) begin nerr++; $display("FAIL t3_timeout: got timeout expected completion"); end
    nchk++;
    if (bm !== 4'd2) begin nerr++; $display("FAIL t3_best_mode: got %0d expected 2", bm); end
    nchk++;
    if (bs !== 12'd40) begin nerr++; $display("FAIL t3_best_sad: got %0d expected 40", bs); end
    nchk++;
    if (rq_dat.size() >= 2) begin
      r = rq_dat[0];
      if (r[(2*LANES+0)*RES_W +: RES_W] !== 9'h1D8) begin nerr++; $display("FAIL t3_res_m2p0: got %0h expected 1d8", r[(2*LANES+0)*RES_W +: RES_W]); end
      nchk++;
      r = rq_dat[1];
      if (r[(5*LANES+1)*RES_W +: RES_W] !== 9'h028) begin nerr++; $display("FAIL t3_res_m5p5: got %0h expected 028", r[(5*LANES+1)*RES_W +: RES_W]); end
      nchk++;
    end else begin
      nerr++;
      $display("FAIL t3_res_count: got %0d expected %0d", rq_dat.size(), BEATS);
      nchk++;
    end
  endtask

  // Residual sink stalls for 3 cycles after beat 1: input must back off, nothing lost or reordered.
  task automatic test_stall;
    int a0, a1, a2, a3, seen;
    bit t0, t1, t2, t3, to2;
    logic [3:0] bm;
    logic [11:0] bs;
    for (int i = 0; i < NPIX; i++) begin
      blk_mb[i] = 8 * i + 3;
      for (int m = 0; m < NMODES; m++) blk_pred[m][i] = 50 + m;
    end
    rq_dat.delete();
    rq_last.delete();
    send_beat(0, a0, t0);
    send_beat(1, a1, t1);
    res_ready = 1'b0;
    fork
      send_beat(2, a2, t2);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          if (in_ready !== 1'b0) begin nerr++; $display("FAIL t4_stall_in_ready%0d: got %0b expected 0", k, in_ready); end
          nchk++;
          if (res_valid !== 1'b1 || res_data !== exp_res(1)) begin
            nerr++;
            $display("FAIL t4_stall_hold%0d: got valid=%0b data=%0h expected 1 and %0h", k, res_valid, res_data, exp_res(1));
          end
          nchk++;
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
      end
    join
    send_beat(3, a3, t3);
    wait_decision(seen, bm, bs, to2);
    if (t0 || t1 || t2 || t3 || to2) begin nerr++; $display("FAIL t4_timeout: got timeout expected completion"); end
    nchk++;
    if (rq_dat.size() !== BEATS) begin nerr++; $display("FAIL t4_res_count: got %0d expected %0d", rq_dat.size(), BEATS); end
    nchk++;
    for (int b = 0; b < BEATS && b < rq_dat.size(); b++) begin
      if (rq_dat[b] !== exp_res(b)) begin nerr++; $display("FAIL t4_res_beat%0d: got %0h expected %0h", b, rq_dat[b], exp_res(b)); end
      nchk++;
      if (rq_last[b] !== (b == BEATS - 1)) begin nerr++; $display("FAIL t4_last_beat%0d: got %0b expected %0b", b, rq_last[b], (b == BEATS - 1)); end
      nchk++;
    end
  endtask

  // Reset after two beats of a high-SAD block, then an exact block must report SAD 0.
  task automatic test_reset_mid_block;
    int a0, a1, acc, seen;
    bit t0, t1, to, to2;
    logic [3:0] bm;
    logic [11:0] bs;
    set_flat(0, 255);
    send_beat(0, a0, t0);
    send_beat(1, a1, t1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (in_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== '0 || res_last !== 1'b0 ||
        sad_valid !== 1'b0 || best_mode !== 4'd0 || best_sad !== 12'd0) begin
      nerr++;
      $display("FAIL t5_reset_outputs: got rdy=%0b rv=%0b rl=%0b sv=%0b mode=%0d sad=%0d expected all 0",
               in_ready, res_valid, res_last, sad_valid, best_mode, best_sad);
    end
    nchk++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rq_dat.delete();
    rq_last.delete();
    set_flat(77, 77);
    send_block(acc, to);
    wait_decision(seen, bm, bs, to2);
    if (t0 || t1 || to || to2) begin nerr++; $display("FAIL t5_timeout: got timeout expected completion"); end
    nchk++;
    if (bs !== 12'd0) begin nerr++; $display("FAIL t5_best_sad: got %0d expected 0", bs); end
    nchk++;
    if (bm !== 4'd0) begin nerr++; $display("FAIL t5_best_mode: got %0d expected 0", bm); end
    nchk++;
    if (rq_dat.size() !== BEATS) begin nerr++; $display("FAIL t5_res_count: got %0d expected %0d", rq_dat.size(), BEATS); end
    nchk++;
    for (int b = 0; b < BEATS && b < rq_dat.size(); b++) begin
      if (rq_dat[b] !== '0) begin nerr++; $display("FAIL t5_res_beat%0d: got %0h expected 0", b, rq_dat[b]); end
      nchk++;
    end
  endtask

`ifdef INTRA_SAD_MODE_MASK_EN
  // Mode 0 lowest (16), mode 4 next (32), rest 160; mask excludes mode 0, and is only sampled on beat 0.
  task automatic test_mask;
    int acc, seen, a;
    bit to, to2, t;
    logic [3:0] bm;
    logic [11:0] bs;
    set_flat(100, 110);
    for (int i = 0; i < NPIX; i++) begin
      blk_pred[0][i] = 101;
      blk_pred[4][i] = 102;
    end
    mode_mask = 9'h1FE;
    send_beat(0, a, to);
    mode_mask = 9'h000;
    for (int b = 1; b < BEATS; b++) begin
      send_beat(b, a, t);
      to = to | t;
    end
    wait_decision(seen, bm, bs, to2);
    if (to || to2) begin nerr++; $display("FAIL t6_timeout: got timeout expected completion"); end
    nchk++;
    if (bm !== 4'd4) begin nerr++; $display("FAIL t6_best_mode: got %0d expected 4", bm); end
    nchk++;
    if (bs !== 12'd32) begin nerr++; $display("FAIL t6_best_sad: got %0d expected 32", bs); end
    nchk++;
    mode_mask = 9'h000;
    send_block(acc, to);
    wait_decision(seen, bm, bs, to2);
    if (to || to2) begin nerr++; $display("FAIL t6_zero_timeout: got timeout expected completion"); end
    nchk++;
    if (bm !== 4'd0 || bs !== 12'hFFF) begin
      nerr++;
      $display("FAIL t6_zero_mask: got mode=%0d sad=%0h expected 0 and fff", bm, bs);
    end
    nchk++;
    mode_mask = '1;
  endtask
`endif

  initial begin
    test_reset();
    test_best_exact();
    test_extreme_hold();
    test_tie();
    test_stall();
    test_reset_mid_block();
`ifdef INTRA_SAD_MODE_MASK_EN
    test_mask();
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
